// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/exec/write-back sequencer for the shared 8-bit ALU.
// Fetches 9-bit instructions, drives ALU_OP and R1 write-back, resolves BEQZ and stops on HALT.
module alu_seq_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [8:0]       imem_data,
  output logic [4:0]       ALU_OP,
  input  logic [7:0]       alu_out,
  input  logic             alu_zero,
  output logic [1:0]       rf_rs_addr,
  output logic [1:0]       rf_rt_addr,
  output logic             rf_we,
  output logic [7:0]       rf_wdata,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_BEQZ = 4'b0011;

  state_t                  state, state_nxt;
  logic [PC_W-1:0]         pc, pc_nxt;
  logic [8:0]              ir;
  logic [7:0]              res;
  logic                    z;
  logic                    start_ok;
  logic [3:0]              op;
  logic signed [PC_W-1:0]  off_sext;

  function automatic logic is_write_op(input logic [3:0] opc);
    case (opc)
      4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1100: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [3:0] opc);
    return is_write_op(opc) || (opc == OP_HALT) || (opc == OP_BEQZ);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign op          = ir[8:5];
  assign off_sext    = {{(PC_W-5){ir[4]}}, ir[4:0]};
  assign imem_addr   = pc;
  assign rf_rs_addr  = ir[4:3];
  assign rf_rt_addr  = ir[2:1];
  assign rf_wdata    = rf_we ? res : 8'd0;

  // Branch target wraps modulo 2^PC_W.
  always_comb begin
    pc_nxt = pc + PC_W'(1);
    if (op == OP_BEQZ && z)
      pc_nxt = pc + $unsigned(off_sext);
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    imem_req  = 1'b0;
    ALU_OP    = 5'd0;
    rf_we     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack)
          state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        ALU_OP    = {1'b0, op};
        state_nxt = (op == OP_HALT) ? S_HALTED : S_WB;
      end
      S_WB: begin
        busy      = 1'b1;
        rf_we     = is_write_op(op);
        state_nxt = S_FETCH;
      end
      S_HALTED: begin
        done = 1'b1;
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Async reset aborts any in-flight instruction before its write or PC update lands.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      res         <= '0;
      z           <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        pc          <= '0;
        illegal     <= 1'b0;
        instr_count <= '0;
      end
      if (state == S_FETCH && imem_ack)
        ir <= imem_data;
      if (state == S_EXEC) begin
        res         <= alu_out;
        z           <= alu_zero;
        instr_count <= sat_inc(instr_count);
      end
      if (state == S_WB) begin
        pc <= pc_nxt;
        if (!is_legal_op(op))
          illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: steps instructions cycle by cycle with a
// write-back scoreboard fed at EXEC and drained whenever rf_we is seen.
module tb_alu_seq_ctrl;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             CLK;
  logic             Reset_n;
  logic             start;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [8:0]       imem_data;
  logic [4:0]       ALU_OP;
  logic [7:0]       alu_out;
  logic             alu_zero;
  logic [1:0]       rf_rs_addr;
  logic [1:0]       rf_rt_addr;
  logic             rf_we;
  logic [7:0]       rf_wdata;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  logic [8:0]       imem [256];
  logic [7:0]       sb_q [$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               exp_cnt = 0;

  alu_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ALU_OP(ALU_OP), .alu_out(alu_out), .alu_zero(alu_zero),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .illegal(illegal), .instr_count(instr_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tb_writes(input logic [3:0] opc);
    return opc inside {4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                       4'b1000, 4'b1001, 4'b1010, 4'b1100};
  endfunction

  always @(negedge CLK) begin
    if (Reset_n && rf_we) begin
      if (sb_q.size() == 0) chk("sb_unexpected_we", 32'(rf_we), 32'd0);
      else                  chk("sb_wdata", 32'(rf_wdata), 32'(sb_q.pop_front()));
    end
  end

  // Entered at the negedge of the first FETCH cycle; leaves at the negedge of WB (or HALTED).
  task automatic do_instr(input logic [PC_W-1:0] pc_exp, input int waits,
                          input logic [7:0] aval, input logic az);
    logic [8:0] ins;
    logic [3:0] opc;
    ins = imem[pc_exp];
    opc = ins[8:5];
    for (int k = 0; k <= waits; k++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(pc_exp));
      chk("fetch_aluop", 32'(ALU_OP), 32'd0);
      imem_ack  = (k == waits);
      imem_data = imem[imem_addr];
      @(negedge CLK);
    end
    imem_ack  = 1'b0;
    imem_data = 9'h1AB;
    chk("exec_op", 32'(ALU_OP), 32'({1'b0, opc}));
    chk("exec_rs", 32'(rf_rs_addr), 32'(ins[4:3]));
    chk("exec_rt", 32'(rf_rt_addr), 32'(ins[2:1]));
    chk("exec_req", 32'(imem_req), 32'd0);
    alu_out  = aval;
    alu_zero = az;
    if (tb_writes(opc)) sb_q.push_back(aval);
    exp_cnt++;
    @(negedge CLK);
    chk("count", 32'(instr_count), 32'(exp_cnt));
    if (opc != 4'b0000) begin
      chk("wb_we", 32'(rf_we), 32'(tb_writes(opc)));
      chk("wb_busy", 32'(busy), 32'd1);
      chk("wb_aluop", 32'(ALU_OP), 32'd0);
    end
  endtask

  initial begin
    Reset_n   = 1'b1;
    start     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 9'd0;
    alu_out   = 8'd0;
    alu_zero  = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 9'd0;
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_aluop", 32'(ALU_OP), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_wdata", 32'(rf_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_count", 32'(instr_count), 0);
    chk("rst_rs", 32'(rf_rs_addr), 0);
    chk("rst_rt", 32'(rf_rt_addr), 0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_req", 32'(imem_req), 0);

    imem[0] = 9'b1100_01_10_0;  // ADD
    imem[1] = 9'b0011_00100;    // BEQZ +4
    imem[5] = 9'b0011_11110;    // BEQZ -2
    imem[3] = 9'b0011_00010;    // BEQZ +2
    imem[6] = 9'b0011_11100;    // BEQZ -4
    imem[2] = 9'b1011_00000;    // undefined opcode
    imem[4] = 9'b0000_00000;    // HALT

    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    do_instr(8'd0, 0, 8'd14, 1'b0);
    @(negedge CLK);
    do_instr(8'd1, 3, 8'd0, 1'b1);   // delayed ack, taken +4
    @(negedge CLK);
    do_instr(8'd5, 0, 8'd0, 1'b1);   // taken -2
    @(negedge CLK);
    do_instr(8'd3, 0, 8'd0, 1'b1);   // taken +2
    @(negedge CLK);
    do_instr(8'd5, 0, 8'd1, 1'b0);   // not taken
    @(negedge CLK);
    do_instr(8'd6, 0, 8'd0, 1'b1);   // taken -4
    @(negedge CLK);
    do_instr(8'd2, 0, 8'd7, 1'b0);   // illegal
    chk("illegal_in_wb", 32'(illegal), 0);
    @(negedge CLK);
    chk("illegal_set", 32'(illegal), 1);
    do_instr(8'd3, 0, 8'd3, 1'b0);   // not taken -> 4
    @(negedge CLK);
    do_instr(8'd4, 0, 8'd0, 1'b0);   // HALT
    chk("halt_done", 32'(done), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_pc", 32'(imem_addr), 4);
    chk("halt_illegal", 32'(illegal), 1);
    @(negedge CLK);
    chk("halt_hold_done", 32'(done), 1);
    chk("halt_hold_req", 32'(imem_req), 0);

    imem[0]   = 9'b0011_11111;  // BEQZ -1
    imem[255] = 9'b0011_00001;  // BEQZ +1
    start = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
    exp_cnt = 0;
    chk("restart_addr", 32'(imem_addr), 0);
    chk("restart_done", 32'(done), 0);
    chk("restart_illegal", 32'(illegal), 0);
    chk("restart_count", 32'(instr_count), 0);
    do_instr(8'd0, 0, 8'd0, 1'b1);   // 0 - 1 wraps to 255
    @(negedge CLK);
    imem[0] = 9'b0111_10_11_0;       // SUB
    do_instr(8'd255, 0, 8'd0, 1'b1); // 255 + 1 wraps to 0
    @(negedge CLK);
    do_instr(8'd0, 0, 8'hA5, 1'b0);
    #1 Reset_n = 1'b0;
    #1;
    chk("abort_we", 32'(rf_we), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_count", 32'(instr_count), 0);
    chk("abort_addr", 32'(imem_addr), 0);
    chk("abort_rs", 32'(rf_rs_addr), 0);
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    chk("post_abort_req", 32'(imem_req), 0);
    chk("post_abort_busy", 32'(busy), 0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle control FSM that sequences the shared 8-bit ALU. It fetches 9-bit instructions over a request/acknowledge memory port and decodes the 4-bit opcode into ALU_OP. It drives register-file read addresses and the R1 write-back, resolves BEQZ branches from ALU_ZERO, and stops on HALT. It sits between instruction memory, the register file and the combinational ALU, and is the only driver of ALU_OP.

## Interface
Parameters:
- PC_W, 8, program counter / imem address width
- CNT_W, 16, retired-instruction counter width

Ports:
- CLK  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins execution at PC=0 from IDLE or HALTED
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_data valid in this cycle
- imem_data  in  9  instruction word
- ALU_OP  out  5  to ALU; bit 4 always 0
- alu_out  in  8  ALU result
- alu_zero  in  1  ALU_ZERO flag
- rf_rs_addr  out  2  RS read address
- rf_rt_addr  out  2  RT read address
- rf_we  out  1  write R1 this cycle
- rf_wdata  out  8  R1 write data
- busy  out  1  high in FETCH/EXEC/WB
- done  out  1  high in HALTED
- illegal  out  1  sticky; an undefined opcode was executed
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- Instruction fields: op=IR[8:5], rs=IR[4:3], rt=IR[2:1], IR[0] reserved; BEQZ offset off=IR[4:0], signed.
- Opcodes: 0000 HALT, 0001 SLT, 0011 BEQZ, 0100 SL, 0101 SR, 0110 CL, 0111 SUB, 1000 OR, 1001 AND, 1010 SGTE, 1100 ADD. All others are illegal.
- States: IDLE, FETCH, EXEC, WB, HALTED.
- IDLE: start -> FETCH with PC=0.
- FETCH:
  - imem_req=1.
  - On imem_ack, latch IR=imem_data and go to EXEC.
  - Without ack, stay in FETCH with imem_addr held.
- EXEC:
  - ALU_OP={0,op}.
  - Latch RES=alu_out and Z=alu_zero.
  - op=HALT -> HALTED, PC unchanged.
  - Any other op -> WB.
- WB:
  - Writing ops (SLT, SL, SR, CL, SUB, OR, AND, SGTE, ADD): rf_we=1, rf_wdata=RES.
  - BEQZ:
    - No write.
    - Z=1: PC=PC+sext(off), taken.
    - Z=0: PC=PC+1.
  - Illegal op: no write, illegal<=1, PC=PC+1.
  - All other ops: PC=PC+1.
  - Next state FETCH.
- HALTED: start -> FETCH with PC=0; done and illegal clear.
- instr_count increments once per instruction on leaving EXEC, including HALT and illegal ops. It saturates at 2^CNT_W-1 and clears on start.
- start is ignored while busy=1.
- PC arithmetic is modulo 2^PC_W: 255+1=0 and 0+sext(-1)=255.
- rf_rs_addr=IR[4:3] and rf_rt_addr=IR[2:1] at all times.
- ALU_OP=0 outside EXEC.

## Timing
- Reset (async, immediate) values:
  - Outputs: ALU_OP, imem_req, imem_addr, rf_we, rf_wdata, busy, done, illegal, instr_count, rf_rs_addr and rf_rt_addr all 0.
  - Internal: state IDLE; PC, IR, RES and Z all 0.
- Reset asserted mid-instruction aborts it: rf_we drops immediately, and no write or PC update completes.
- Latency with zero-wait memory (ack in the first FETCH cycle): 3 cycles per instruction (FETCH, EXEC, WB); HALT takes 2 cycles to reach HALTED.
- Each wait cycle adds 1 to FETCH.
- The ALU is combinational. alu_out and alu_zero are sampled at the rising edge that ends EXEC.
- rf_we is a 1-cycle pulse in WB, written by the register file at the edge ending WB.
- The new PC is visible on imem_addr in the next FETCH cycle.
- done rises on the first HALTED cycle.
- busy falls on the same edge that done rises.

## Test plan
- Zero-wait memory; imem[0]=ADD rs=1 rt=2 (9'b1100_01_10_0); ALU stub returns 14 -> ALU_OP=01100 in cycle 2, rf_we=1 with rf_wdata=14 in cycle 3, imem_addr=1 in cycle 4, instr_count=1.
- BEQZ at PC=5 with off=-2 (9'b0011_11110):
  - alu_zero=1 -> next imem_addr=3, rf_we stays 0.
  - Repeat with alu_zero=0 -> next imem_addr=6.
- imem_ack delayed 3 cycles -> imem_req high and imem_addr stable for 4 cycles; EXEC starts the cycle after ack.
- Illegal opcode 1011 at PC=2 -> illegal=1 after WB, no rf_we, next imem_addr=3.
- BEQZ taken with off=+1 at PC=255 -> next imem_addr=0.
- HALT at PC=4:
  - done=1 two cycles after ack, busy=0, PC held, instr_count incremented.
  - start -> imem_addr=0, done=0, illegal=0.
  - Reset_n pulled low during a WB cycle -> rf_we=0 immediately, state IDLE, instr_count=0.
